logic_unit_seq: RTL and testbench
=================================

# logic_unit_seq

Parametrised, slice-serial bitwise logic unit for the datapath ALU. It is the successor to the fixed 32-bit single-function combinational gate arrays. It latches two operands and an opcode on `start`, then computes the result SLICE bits per clock, LSB slice first. The full result is published on `Rz` with a one-cycle `done` pulse and a zero flag. The ALU control FSM uses it where area matters more than single-cycle logic ops.

## Interface
- `WIDTH`, 32: operand/result width in bits. Legal values are 1..64.
- `SLICE`, 8: bits processed per cycle. Must divide WIDTH; `N = WIDTH/SLICE` cycles per op.
- `clk`  in  1  rising-edge clock
- `clr_n`  in  1  synchronous, active-low reset
- `start`  in  1  request a new operation; accepted only when not busy
- `op`  in  3  opcode, sampled with `start`
- `Ra`  in  WIDTH  operand A, sampled with `start`
- `Rb`  in  WIDTH  operand B, sampled with `start`
- `Rz`  out  WIDTH  last completed result, registered
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse: `Rz`/`zero` just updated
- `zero`  out  1  1 when the last completed result == 0

## Operation
- Opcodes, applied bitwise:
  - 000 AND, 001 OR, 010 XOR, 011 NOR
  - 100 NAND, 101 XNOR, 110 NOT Ra (Rb ignored), 111 ANDN (Ra & ~Rb)
- States:
  - IDLE: `start` → RUN. Latch Ra, Rb, op into operand registers; clear slice counter `cnt` and the work register.
  - RUN: each cycle computes slice `cnt` (bits `[cnt*SLICE +: SLICE]`) of the work register from the latched operands, then increments `cnt`. When `cnt == N-1` is processed → DONE. At that same edge, copy the work register to `Rz` and set `zero` = (result == 0).
  - DONE: `done`=1 for this one cycle. `start` here → RUN, latching as in IDLE (back-to-back). Otherwise → IDLE.
- `Rz` and `zero` change only at the completing edge. They hold the previous result during RUN; partial slices are never visible.
- `start` while in RUN is ignored and not queued. Operands and op may change freely after the accepting edge.
- `cnt` width is `$clog2(N)`, minimum 1 bit. No wrap-around beyond N-1.

## Timing
- Reset (`clr_n`=0 at a rising edge):
  - State → IDLE, `cnt` = 0.
  - `Rz` = 0, `zero` = 0, `busy` = 0, `done` = 0.
  - Reset dominates `start` in the same cycle.
  - Reset during RUN aborts the op; no `done` is produced.
- Latency: `start` accepted at edge E0.
  - `busy`=1 for cycles E0..E(N-1).
  - `Rz`/`zero` update at edge EN; `done`=1 and `busy`=0 in the cycle after EN.
- Throughput:
  - With `start` held in the DONE cycle, one result per N+1 cycles.
  - `busy` is low in the DONE cycle.
- SLICE == WIDTH (N=1): result at E1, `done` in the cycle after E1.
- `busy`, `done`, `Rz` and `zero` are all registered outputs; there is no combinational path from inputs.

## Test plan
- **OR, default parameters.** `start` with op=001, Ra=AAAAAAAA, Rb=55555555 → `busy` for 4 cycles; at the 4th edge `Rz`=FFFFFFFF and `zero`=0; `done` high exactly 1 cycle.
- **XOR to zero, then ANDN.**
  - XOR op=010 with Ra=Rb=ABCD1234 → `Rz`=00000000, `zero`=1.
  - Then ANDN op=111 with Ra=FFFFFFFF, Rb=ABCD1234 → `Rz`=5432EDCB, `zero`=0.
- **Ignored start, changed inputs.**
  - Op: OR with Ra=00000037, Rb=00000073.
  - Pulse `start` again in RUN with Ra=FFFFFFFF, and change Ra/Rb every cycle.
  - Required: `Rz`=00000077, exactly one `done`.
- **Reset mid-op.** Assert `clr_n`=0 in the 2nd RUN cycle of a NOR → next cycle `Rz`=0, `busy`=0, `done`=0, with no later `done`. A fresh NOT of Ra=0 then gives `Rz`=FFFFFFFF.
- **Back-to-back.** Raise `start` in the DONE cycle with AND FFFF0000 & 0F0F0F0F → second result 0F0F0000 appears 5 cycles after the first `done`.
- **WIDTH=16, SLICE=16.** NAND of FFFF and 00FF → `Rz`=FF00, `done` one cycle after the accepting edge.

Source files
------------

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: slice-serial bitwise logic unit (AND/OR/XOR/NOR/NAND/XNOR/NOT/ANDN).
// Latches Ra/Rb/op on an accepted start, then computes SLICE result bits per clock
// (LSB slice first). The full result is published on Rz only at the completing edge.
// Latency: N = WIDTH/SLICE cycles of busy, then a one-cycle done pulse. A start
// raised in the done cycle is accepted back-to-back. A start raised while busy is dropped.
// Ports:
//   clk    rising-edge clock
//   clr_n  synchronous active-low reset
//   start  request an operation (accepted when not busy)
//   op     opcode, sampled with start
//   Ra     operand A, sampled with start
//   Rb     operand B, sampled with start
//   Rz     last completed result
//   busy   operation in progress
//   done   one-cycle pulse when Rz/zero were just updated
//   zero   last completed result == 0
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic [WIDTH-1:0] Rz,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_rz;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_full;
  logic [WIDTH-1:0] w_work_nxt;

  // Full-width function of the latched operands; only the current slice of it
  // is committed into the work register each cycle.
  always_comb begin
    w_full = '0;
    case (r_op)
      3'b000:  w_full = r_a & r_b;
      3'b001:  w_full = r_a | r_b;
      3'b010:  w_full = r_a ^ r_b;
      3'b011:  w_full = ~(r_a | r_b);
      3'b100:  w_full = ~(r_a & r_b);
      3'b101:  w_full = ~(r_a ^ r_b);
      3'b110:  w_full = ~r_a;
      default: w_full = r_a & ~r_b;
    endcase
  end

  // Merge slice r_cnt into the work register; constant part-select bases keep
  // the mux structure simple for every legal WIDTH/SLICE pair.
  always_comb begin
    w_work_nxt = r_work;
    for (int s = 0; s < N; s++) begin
      if (CW'(s) == r_cnt) begin
        w_work_nxt[s*SLICE +: SLICE] = w_full[s*SLICE +: SLICE];
      end
    end
  end

  assign w_last = (r_cnt == CW'(N - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_accept    = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_rz    <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // busy/done are decoded from the next state so they are flops, not logic on r_state.
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_op   <= op;
        r_a    <= Ra;
        r_b    <= Rb;
        r_cnt  <= '0;
        r_work <= '0;
      end else if (r_state == S_RUN) begin
        r_work <= w_work_nxt;
        if (w_last) begin
          // Publish including the slice computed on this same edge.
          r_rz   <= w_work_nxt;
          r_zero <= (w_work_nxt == '0);
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign Rz   = r_rz;
  assign zero = r_zero;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_logic_unit_seq.sv
module tb_logic_unit_seq;

  logic        clk = 1'b0;
  logic        clr_n;
  // instance A: WIDTH=32, SLICE=8
  logic        start_a;
  logic [2:0]  op_a;
  logic [31:0] ra_a, rb_a, rz_a;
  logic        busy_a, done_a, zero_a;
  // instance B: WIDTH=16, SLICE=16
  logic        start_b;
  logic [2:0]  op_b;
  logic [15:0] ra_b, rb_b, rz_b;
  logic        busy_b, done_b, zero_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int done_cnt_a = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut_a (
    .clk(clk), .clr_n(clr_n), .start(start_a), .op(op_a), .Ra(ra_a), .Rb(rb_a),
    .Rz(rz_a), .busy(busy_a), .done(done_a), .zero(zero_a));

  logic_unit_seq #(.WIDTH(16), .SLICE(16)) dut_b (
    .clk(clk), .clr_n(clr_n), .start(start_b), .op(op_b), .Ra(ra_b), .Rb(rb_b),
    .Rz(rz_b), .busy(busy_b), .done(done_b), .zero(zero_b));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference logic function computed on whole words.
  function automatic logic [63:0] lf(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ~(a & b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a & ~b;
    endcase
  endfunction

  // Behavioural model: an accepted op yields its whole-word result after
  // N edges; until then outputs hold; starts during an op are dropped.
  logic [31:0] ma_rz, ma_res;  logic ma_zero, ma_done; int ma_left;
  logic [15:0] mb_rz, mb_res;  logic mb_zero, mb_done; int mb_left;

  always @(posedge clk) begin
    logic [63:0] t;
    cyc++;
    if (!clr_n) begin
      ma_rz = '0; ma_zero = 0; ma_done = 0; ma_left = 0;
      mb_rz = '0; mb_zero = 0; mb_done = 0; mb_left = 0;
    end else begin
      ma_done = 0;
      if (ma_left > 0) begin
        ma_left--;
        if (ma_left == 0) begin ma_rz = ma_res; ma_zero = (ma_res == 0); ma_done = 1; end
      end else if (start_a) begin
        t = lf(op_a, {32'h0, ra_a}, {32'h0, rb_a}); ma_res = t[31:0]; ma_left = 4;
      end
      mb_done = 0;
      if (mb_left > 0) begin
        mb_left--;
        if (mb_left == 0) begin mb_rz = mb_res; mb_zero = (mb_res == 0); mb_done = 1; end
      end else if (start_b) begin
        t = lf(op_b, {48'h0, ra_b}, {48'h0, rb_b}); mb_res = t[15:0]; mb_left = 1;
      end
    end
  end

  // Compare process: DUT vs model on every cycle after reset has been applied.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_rz",   {32'h0, rz_a},   {32'h0, ma_rz});
      chk("a_zero", {63'h0, zero_a}, {63'h0, ma_zero});
      chk("a_busy", {63'h0, busy_a}, {63'h0, 1'(ma_left > 0)});
      chk("a_done", {63'h0, done_a}, {63'h0, ma_done});
      chk("b_rz",   {48'h0, rz_b},   {48'h0, mb_rz});
      chk("b_zero", {63'h0, zero_b}, {63'h0, mb_zero});
      chk("b_busy", {63'h0, busy_b}, {63'h0, 1'(mb_left > 0)});
      chk("b_done", {63'h0, done_b}, {63'h0, mb_done});
      if (done_a) done_cnt_a++;
    end
  end

  task automatic issue_a(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_a = 1'b1; op_a = o; ra_a = a; rb_a = b;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // Called in the cycle after the accepting edge; returns at the done cycle.
  task automatic wait_done_a(output int nb);
    nb = 0;
    for (int k = 0; k < 40 && !done_a; k++) begin
      if (busy_a) nb++;
      @(negedge clk);
    end
    if (!done_a) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int nb, d0, t1, t2;
    clr_n = 0; start_a = 0; op_a = 0; ra_a = 0; rb_a = 0;
    start_b = 0; op_b = 0; ra_b = 0; rb_b = 0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_rz",   {32'h0, rz_a}, 64'h0);
    chk("rst_zero", {63'h0, zero_a}, 64'h0);
    chk("rst_busy", {63'h0, busy_a}, 64'h0);
    chk("rst_done", {63'h0, done_a}, 64'h0);
    clr_n = 1;

    // OR, default parameters
    issue_a(3'b001, 32'hAAAAAAAA, 32'h55555555);
    wait_done_a(nb);
    chk("or_busy_cycles", 64'(nb), 64'd4);
    chk("or_rz",   {32'h0, rz_a}, 64'hFFFFFFFF);
    chk("or_zero", {63'h0, zero_a}, 64'h0);
    chk("or_done_busy", {63'h0, busy_a}, 64'h0);
    @(negedge clk);
    chk("or_done_one_cycle", {63'h0, done_a}, 64'h0);

    // XOR to zero, then ANDN
    issue_a(3'b010, 32'hABCD1234, 32'hABCD1234);
    wait_done_a(nb);
    chk("xor_rz",   {32'h0, rz_a}, 64'h0);
    chk("xor_zero", {63'h0, zero_a}, 64'h1);
    issue_a(3'b111, 32'hFFFFFFFF, 32'hABCD1234);
    wait_done_a(nb);
    chk("andn_rz",   {32'h0, rz_a}, 64'h5432EDCB);
    chk("andn_zero", {63'h0, zero_a}, 64'h0);

    // Ignored start during RUN, inputs changing every cycle
    @(negedge clk);
    d0 = done_cnt_a;
    issue_a(3'b001, 32'h00000037, 32'h00000073);
    start_a = 1'b1; ra_a = 32'hFFFFFFFF; rb_a = $urandom;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ra_a = $urandom; rb_a = $urandom; op_a = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    wait_done_a(nb);
    chk("ign_rz", {32'h0, rz_a}, 64'h77);
    repeat (8) @(negedge clk);
    chk("ign_one_done", 64'(done_cnt_a - d0), 64'd1);

    // Reset in the 2nd RUN cycle of a NOR
    issue_a(3'b011, 32'h12345678, 32'h0F0F0F0F);
    @(negedge clk);
    clr_n = 0;
    @(negedge clk);
    clr_n = 1;
    chk("rstmid_rz",   {32'h0, rz_a}, 64'h0);
    chk("rstmid_busy", {63'h0, busy_a}, 64'h0);
    chk("rstmid_done", {63'h0, done_a}, 64'h0);
    d0 = done_cnt_a;
    repeat (8) @(negedge clk);
    chk("rstmid_no_done", 64'(done_cnt_a - d0), 64'd0);
    issue_a(3'b110, 32'h0, 32'h5A5A5A5A);
    wait_done_a(nb);
    chk("not_rz", {32'h0, rz_a}, 64'hFFFFFFFF);

    // Back-to-back: start raised in the DONE cycle
    issue_a(3'b010, 32'h1, 32'h3);
    wait_done_a(nb);
    t1 = cyc;
    chk("b2b_first_rz", {32'h0, rz_a}, 64'h2);
    start_a = 1'b1; op_a = 3'b000; ra_a = 32'hFFFF0000; rb_a = 32'h0F0F0F0F;
    @(negedge clk);
    start_a = 1'b0;
    chk("b2b_busy_after_done", {63'h0, busy_a}, 64'h1);
    wait_done_a(nb);
    t2 = cyc;
    chk("b2b_gap", 64'(t2 - t1), 64'd5);
    chk("b2b_rz", {32'h0, rz_a}, 64'h0F0F0000);

    // WIDTH=16, SLICE=16: single-cycle op
    @(negedge clk);
    start_b = 1'b1; op_b = 3'b100; ra_b = 16'hFFFF; rb_b = 16'h00FF;
    @(negedge clk);
    start_b = 1'b0; ra_b = 16'h0; rb_b = 16'h0;
    chk("w16_busy", {63'h0, busy_b}, 64'h1);
    chk("w16_done_early", {63'h0, done_b}, 64'h0);
    @(negedge clk);
    chk("w16_done", {63'h0, done_b}, 64'h1);
    chk("w16_rz", {48'h0, rz_b}, 64'hFF00);
    chk("w16_zero", {63'h0, zero_b}, 64'h0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
